uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- 8N1 UART receive path; the counterpart of the team's uart_transmitter, sharing the same external baud-tick scheme.
- Samples an asynchronous serial line using an oversampling clock enable (OVERSAMPLE ticks per bit).
- Validates the start bit at mid-bit, shifts in data LSB first, and checks the stop bit.
- Presents each received byte with a one-cycle valid strobe, or a one-cycle framing-error strobe. Sits between the pad and the UART register/FIFO layer.

Parameters:
- OVERSAMPLE, 16, i_CLK_ENABLE ticks per bit period; even, >= 4.
- DATA_BITS, 8, data bits per frame.

Ports:
- i_CLK  in  1  system clock
- i_RESET  in  1  synchronous reset, active-high
- i_CLK_ENABLE  in  1  oversample tick, OVERSAMPLE x baud, one i_CLK wide
- i_RX  in  1  asynchronous serial input, idle high
- o_DATA_OUT  out  DATA_BITS  last good received byte
- o_DATA_VALID  out  1  one-cycle strobe: o_DATA_OUT updated
- o_FRAMING_ERROR  out  1  one-cycle strobe: stop bit sampled low
- o_RX_BUSY  out  1  high while a frame is in progress

Behaviour:
- Reset: i_RESET is synchronous, active-high; clock is i_CLK.
  - Reset values: o_DATA_OUT=0, o_DATA_VALID=0, o_FRAMING_ERROR=0, o_RX_BUSY=0.
  - Synchronizer flops reset to 1. FSM goes to IDLE; tick and bit counters clear to 0.
  - Reset mid-frame abandons the frame silently.
- Synchronizer: 2-FF on i_RX, clocked every i_CLK, not gated by i_CLK_ENABLE. A third flop holds the previous synced value for edge detect.
- Gating: FSM, counters and shift register advance only on cycles with i_CLK_ENABLE=1. They hold otherwise.
- States:
  - IDLE: o_RX_BUSY=0. On a tick where synced RX is low and previous synced RX was high, go to START, tick_cnt=0.
  - START: o_RX_BUSY=1. Count ticks. On the tick where tick_cnt reaches OVERSAMPLE/2-1:
    - if synced RX is low, go to DATA with tick_cnt=0, bit_cnt=0;
    - else go to IDLE (glitch rejected, no strobes).
  - DATA: on each tick where tick_cnt reaches OVERSAMPLE-1, tick_cnt wraps to 0.
    - Shift synced RX into the MSB of the shift register (shift right), bit_cnt+1.
    - After the DATA_BITS-th sample, go to STOP.
  - STOP: on the tick where tick_cnt reaches OVERSAMPLE-1, sample synced RX:
    - high: load o_DATA_OUT from the shift register; o_DATA_VALID=1 for exactly one i_CLK cycle.
    - low: o_FRAMING_ERROR=1 for one cycle; o_DATA_OUT unchanged.
    - Either way, go to IDLE.
- Strobes are registered on the sampling tick edge. They deassert on the next i_CLK edge regardless of i_CLK_ENABLE.
- Break/stuck-low line: after a framing error, IDLE re-arms only after a high-to-low transition. No repeated frames are decoded while the line is held low.
- o_DATA_VALID and o_FRAMING_ERROR are mutually exclusive.
- Widths:
  - tick_cnt: $clog2(OVERSAMPLE) bits, wraps naturally.
  - bit_cnt: $clog2(DATA_BITS+1) bits.
- Sample points relative to the detected falling-edge tick (OVERSAMPLE=16): start at tick 8, data bit k at 8+16(k+1), stop at 152.

Decomposition:
- Package uart_pkg:
  - rx/tx state encodings (IDLE/START/DATA/STOP, 2-bit);
  - default OVERSAMPLE and DATA_BITS constants;
  - line idle level constant.
- One sub-module, uart_rx_sync: 2-FF synchronizer plus previous-value flop, reset to 1. Outputs synced RX and a falling-edge flag.

Test Plan:
- 0xA5 framed correctly, i_CLK_ENABLE=1 every cycle:
  - o_DATA_VALID pulses once about 152 ticks (+2 sync cycles) after the falling edge;
  - o_DATA_OUT=0xA5; o_RX_BUSY high throughout, low after.
- Start glitch, RX low for 4 ticks then high:
  - no o_DATA_VALID, no o_FRAMING_ERROR;
  - returns to IDLE by tick 8; a following 0x3C frame is received as 0x3C.
- 0x3C with stop bit driven low:
  - o_FRAMING_ERROR pulses one cycle;
  - o_DATA_OUT stays at the prior 0xA5; line held low afterward produces no further strobes.
- Back-to-back 0x00 then 0xFF, zero idle gap:
  - two o_DATA_VALID pulses with o_DATA_OUT=0x00 then 0xFF.
- i_RESET asserted during data bit 3 of a frame:
  - next cycle all outputs 0 and o_RX_BUSY=0;
  - a subsequent 0x5A frame is received as 0x5A.
- i_CLK_ENABLE pulsing every 4th i_CLK, frame 0x81:
  - o_DATA_OUT=0x81; o_DATA_VALID is exactly one i_CLK cycle wide.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame geometry and line levels.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int   DEF_OVERSAMPLE = 16;
  localparam int   DEF_DATA_BITS  = 8;
  localparam logic LINE_IDLE      = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the async RX pad plus a previous-value flop for falling-edge detect.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rx_async,
  output logic rx_sync,
  output logic rx_fall
);

  logic rx_meta_p0;
  logic rx_sync_p1;
  logic rx_prev_p2;

  // Flops reset to the idle level so reset itself never looks like a start edge
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_p0 <= LINE_IDLE;
      rx_sync_p1 <= LINE_IDLE;
      rx_prev_p2 <= LINE_IDLE;
    end else begin
      rx_meta_p0 <= rx_async;
      rx_sync_p1 <= rx_meta_p0;
      rx_prev_p2 <= rx_sync_p1;
    end
  end

  assign rx_sync = rx_sync_p1;
  assign rx_fall = rx_prev_p2 & ~rx_sync_p1;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive path: mid-bit sampling on an oversample tick, byte/framing-error strobes.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DATA_BITS  = DEF_DATA_BITS
) (
  input  logic                 i_CLK,
  input  logic                 i_RESET,
  input  logic                 i_CLK_ENABLE,
  input  logic                 i_RX,
  output logic [DATA_BITS-1:0] o_DATA_OUT,
  output logic                 o_DATA_VALID,
  output logic                 o_FRAMING_ERROR,
  output logic                 o_RX_BUSY
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic rx_sync;
  logic rx_fall;

  uart_rx_sync u_sync (
    .clk      (i_CLK),
    .rst      (i_RESET),
    .rx_async (i_RX),
    .rx_sync  (rx_sync),
    .rx_fall  (rx_fall)
  );

  uart_state_t            state, state_n;
  logic [TW-1:0]          tick_cnt, tick_n;
  logic [BW-1:0]          bit_cnt, bit_n;
  logic [DATA_BITS-1:0]   shift_q, shift_n;
  logic [DATA_BITS-1:0]   data_q, data_n;
  logic                   vld_q, vld_n;
  logic                   ferr_q, ferr_n;
  logic                   fall_pend, fall_pend_n;

  // A falling edge between sparse ticks is held until the next tick can act on it
  always_comb begin
    state_n     = state;
    tick_n      = tick_cnt;
    bit_n       = bit_cnt;
    shift_n     = shift_q;
    data_n      = data_q;
    vld_n       = 1'b0;
    ferr_n      = 1'b0;
    fall_pend_n = fall_pend | rx_fall;
    if (i_CLK_ENABLE) begin
      fall_pend_n = 1'b0;
      case (state)
        ST_IDLE: begin
          if ((rx_fall || fall_pend) && !rx_sync) begin
            state_n = ST_START;
            tick_n  = '0;
          end
        end
        ST_START: begin
          if (tick_cnt == HALF_M1) begin
            tick_n  = '0;
            bit_n   = '0;
            state_n = rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          tick_n = (tick_cnt == FULL_M1) ? '0 : tick_cnt + 1'b1;
          if (tick_cnt == FULL_M1) begin
            shift_n = {rx_sync, shift_q[DATA_BITS-1:1]};
            bit_n   = bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) state_n = ST_STOP;
          end
        end
        ST_STOP: begin
          tick_n = (tick_cnt == FULL_M1) ? '0 : tick_cnt + 1'b1;
          if (tick_cnt == FULL_M1) begin
            if (rx_sync) begin
              data_n = shift_q;
              vld_n  = 1'b1;
            end else begin
              ferr_n = 1'b1;
            end
            state_n = ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      data_q    <= '0;
      vld_q     <= 1'b0;
      ferr_q    <= 1'b0;
      fall_pend <= 1'b0;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_n;
      bit_cnt   <= bit_n;
      data_q    <= data_n;
      vld_q     <= vld_n;
      ferr_q    <= ferr_n;
      fall_pend <= fall_pend_n;
    end
  end

  always_ff @(posedge i_CLK) begin
    shift_q <= shift_n;
  end

  assign o_DATA_OUT      = data_q;
  assign o_DATA_VALID    = vld_q;
  assign o_FRAMING_ERROR = ferr_q;
  assign o_RX_BUSY       = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frames built bit-by-bit, outcomes predicted by a frame-level model.
module tb_uart_receiver;

  localparam int OS = 16;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          rx;
  logic [DB-1:0] dout;
  logic          dvld;
  logic          ferr;
  logic          busy;

  uart_receiver #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .i_CLK          (clk),
    .i_RESET        (rst),
    .i_CLK_ENABLE   (en),
    .i_RX           (rx),
    .o_DATA_OUT     (dout),
    .o_DATA_VALID   (dvld),
    .o_FRAMING_ERROR(ferr),
    .o_RX_BUSY      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_err;
    logic [DB-1:0] data;
    int            at;
  } ev_t;

  int  errors = 0;
  int  checks = 0;
  int  en_period = 1;
  int  en_ph = 0;
  int  cyc = 0;
  int  both_cnt = 0;
  int  busy_low_in_frame = 0;
  bit  in_frame = 1'b0;
  ev_t obs_q[$];
  logic [DB-1:0] last_good = '0;

  // Oversample tick generator
  initial begin
    en = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      en_ph = (en_ph + 1) % en_period;
      en    = (en_ph == 0);
    end
  end

  // Strobe monitor: one entry per cycle a strobe is seen
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (dvld === 1'b1 && ferr === 1'b1) both_cnt++;
      if (dvld === 1'b1) obs_q.push_back('{1'b0, dout, cyc});
      if (ferr === 1'b1) obs_q.push_back('{1'b1, dout, cyc});
      if (in_frame && busy !== 1'b1) busy_low_in_frame++;
    end
  end

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (en) k++;
    end
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    wait_ticks(n);
  endtask

  task automatic send_frame(input logic [DB-1:0] b, input bit stop_lvl);
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < DB; i++) begin
      rx = b[i];
      wait_ticks(OS);
    end
    rx = stop_lvl;
    wait_ticks(OS);
  endtask

  // Frame-level reference: a good stop bit delivers the byte, a bad one flags and keeps the old byte
  function automatic ev_t model_frame(input logic [DB-1:0] b, input bit stop_hi);
    ev_t e;
    e.at = 0;
    if (stop_hi) begin
      last_good = b;
      e.is_err  = 1'b0;
    end else begin
      e.is_err  = 1'b1;
    end
    e.data = last_good;
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dout); end
    checks++; if (dvld !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dvld); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", ferr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    last_good = '0;
    idle(8);
    obs_q.delete();
  endtask

  task automatic test_basic();
    ev_t e;
    int  t0;
    int  lat;
    e = model_frame(8'hA5, 1'b1);
    t0 = cyc;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_ticks(4);
        in_frame = 1'b1;
        wait_ticks(146);
        in_frame = 1'b0;
      end
    join
    idle(4);
    checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL basic_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      lat = obs_q[0].at - t0;
      checks++; if (obs_q[0].is_err !== e.is_err || obs_q[0].data !== e.data) begin
        errors++; $display("FAIL basic_event: got err=%b data=%h want err=%b data=%h", obs_q[0].is_err, obs_q[0].data, e.is_err, e.data); end
      checks++; if (lat < 154 || lat > 158) begin errors++; $display("FAIL basic_latency: got %0d want 154..158", lat); end
    end
    checks++; if (busy_low_in_frame !== 0) begin errors++; $display("FAIL basic_busy_during: got %0d low cycles want 0", busy_low_in_frame); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    obs_q.delete();
  endtask

  task automatic test_framing();
    ev_t e;
    e = model_frame(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b0);
    wait_ticks(3 * 10 * OS);
    checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      checks++; if (obs_q[0].is_err !== 1'b1) begin errors++; $display("FAIL ferr_kind: got err=%b want 1", obs_q[0].is_err); end
    end
    checks++; if (dout !== e.data) begin errors++; $display("FAIL ferr_dout: got %h want %h", dout, e.data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_stuck_busy: got %b want 0", busy); end
    idle(32);
    obs_q.delete();
  endtask

  task automatic test_glitch();
    ev_t e;
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b want 0", busy); end
    idle(16);
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL glitch_strobes: got %0d want 0", obs_q.size()); end
    e = model_frame(8'h3C, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(8);
    checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL glitch_next_count: got %0d want 1", obs_q.size()); end
    checks++; if (dout !== e.data) begin errors++; $display("FAIL glitch_next_dout: got %h want %h", dout, e.data); end
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    ev_t e0, e1;
    e0 = model_frame(8'h00, 1'b1);
    e1 = model_frame(8'hFF, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(8);
    checks++; if (obs_q.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", obs_q.size()); end
    if (obs_q.size() > 1) begin
      checks++; if (obs_q[0].data !== e0.data || obs_q[0].is_err) begin errors++; $display("FAIL b2b_first: got %h want %h", obs_q[0].data, e0.data); end
      checks++; if (obs_q[1].data !== e1.data || obs_q[1].is_err) begin errors++; $display("FAIL b2b_second: got %h want %h", obs_q[1].data, e1.data); end
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    ev_t e;
    logic [DB-1:0] b;
    b = 8'hC3;
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      wait_ticks(OS);
    end
    rx = b[3];
    wait_ticks(OS / 2);
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk);
    #1;
    last_good = '0;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rstmid_dout: got %h want 00", dout); end
    checks++; if (busy !== 1'b0 || dvld !== 1'b0 || ferr !== 1'b0) begin
      errors++; $display("FAIL rstmid_ctrl: got busy=%b vld=%b ferr=%b want 0 0 0", busy, dvld, ferr); end
    rst = 1'b0;
    idle(32);
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL rstmid_silent: got %0d strobes want 0", obs_q.size()); end
    e = model_frame(8'h5A, 1'b1);
    send_frame(8'h5A, 1'b1);
    idle(8);
    checks++; if (obs_q.size() !== 1 || dout !== e.data) begin
      errors++; $display("FAIL rstmid_next: got %0d strobes dout=%h want 1 %h", obs_q.size(), dout, e.data); end
    obs_q.delete();
  endtask

  task automatic test_slow_enable();
    ev_t e;
    en_period = 4;
    repeat (8) @(posedge clk);
    #1;
    idle(4);
    e = model_frame(8'h81, 1'b1);
    send_frame(8'h81, 1'b1);
    idle(8);
    checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL slow_width: got %0d valid cycles want 1", obs_q.size()); end
    checks++; if (dout !== e.data) begin errors++; $display("FAIL slow_dout: got %h want %h", dout, e.data); end
    en_period = 1;
    repeat (8) @(posedge clk);
    #1;
    idle(4);
    obs_q.delete();
  endtask

  task automatic test_random();
    ev_t e;
    logic [DB-1:0] b;
    bit stop_hi;
    int gap;
    for (int n = 0; n < 10; n++) begin
      b       = DB'($urandom_range(0, 255));
      stop_hi = ($urandom_range(0, 3) != 0);
      gap     = stop_hi ? $urandom_range(0, 20) : $urandom_range(2, 20);
      e = model_frame(b, stop_hi);
      send_frame(b, stop_hi);
      checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL rand%0d_count: got %0d want 1", n, obs_q.size()); end
      if (obs_q.size() > 0) begin
        checks++; if (obs_q[0].is_err !== e.is_err) begin errors++; $display("FAIL rand%0d_kind: got err=%b want %b", n, obs_q[0].is_err, e.is_err); end
      end
      checks++; if (dout !== e.data) begin errors++; $display("FAIL rand%0d_dout: got %h want %h", n, dout, e.data); end
      obs_q.delete();
      idle(gap);
    end
    idle(8);
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL exclusive_strobes: got %0d overlaps want 0", both_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    test_reset();
    test_basic();
    test_framing();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_slow_enable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
